pluse_seq_ctrl: RTL and testbench
=================================

PLUSE_SEQ_CTRL -- requirements
Module: pluse_seq_ctrl

Interface
REQ-001 SHALL have port clk_sys, input, 1: system clock; all logic is on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1: single-cycle request to run one CPMG sequence.
REQ-004 SHALL have port abort, input, 1: synchronous cancel of a running sequence.
REQ-005 SHALL have port p90_len, input, 16: 90-degree pulse length, in clk_sys cycles.
REQ-006 SHALL have port p180_len, input, 16: 180-degree pulse length, in clk_sys cycles.
REQ-007 SHALL have port tau_len, input, 16: half echo spacing, in clk_sys cycles.
REQ-008 SHALL have port echo_num, input, 16: number of 180-degree pulses.
REQ-009 SHALL have port pluse_load, output, 1: one-cycle strobe that loads bridge/QQ parameters downstream.
REQ-010 SHALL have port state_start, output, 1: high while an RF pulse is being driven.
REQ-011 SHALL have port phase, output, 1: 0 during the 90-degree pulse, 1 during 180-degree pulses.
REQ-012 SHALL have port turn_delay, output, 1: one-cycle strobe on the first cycle of each 180-degree pulse.
REQ-013 SHALL have port quar_delay, output, 1: high during the first tau gap only.
REQ-014 SHALL have ports busy (output, 1: high in any state except IDLE) and done (output, 1: one-cycle strobe at completion).
REQ-015 SHALL have port echo_cnt, output, 16: number of 180-degree pulses completed in the current run.

Function
REQ-016 SHALL implement the FSM states IDLE, LOAD, P90, TAU1, P180, GAP, FIN.
REQ-017 IDLE->LOAD SHALL occur when start=1; p90_len, p180_len, tau_len and echo_num SHALL be latched on that edge and then held for the whole run.
REQ-018 LOAD SHALL last exactly 1 cycle, with pluse_load=1; the next state is P90.
REQ-019 P90 SHALL last max(p90_len,1) cycles, with state_start=1 and phase=0; the next state is TAU1.
REQ-020 TAU1 SHALL last max(tau_len,1) cycles, with quar_delay=1; the next state is P180 if echo_num>0, otherwise FIN.
REQ-021 P180 SHALL last max(p180_len,1) cycles, with state_start=1, phase=1, and turn_delay=1 on its first cycle only; echo_cnt SHALL increment on its last cycle.
REQ-022 GAP SHALL last max(2*tau_len,1) cycles, using a 17-bit count with no overflow.
REQ-023 From GAP, the next state SHALL be P180 if echo_cnt<echo_num, otherwise FIN.
REQ-024 FIN SHALL last 1 cycle, with done=1; the next state is IDLE. echo_cnt SHALL hold its final value until the next LOAD, which clears it.
REQ-025 start SHALL be ignored in every state except IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with all strobes low and done not asserted; abort SHALL take priority over every other transition.
REQ-027 If start and abort are both 1 while in IDLE, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-028 A single down-counter SHALL time each state: it is loaded on state entry, and the state exits when the counter reaches 1.
REQ-029 All outputs SHALL be registered, with no combinational paths from input to output.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE, all counters SHALL be 0, latched parameters SHALL be 0, and every output SHALL be 0.
REQ-031 Reset asserted mid-run SHALL abandon the run immediately; after reset release the block SHALL wait for a new start.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration, the count width (16) and the gap-count width (17).
REQ-033 One sub-module, seq_timer (a loadable down-counter with a terminal-count flag), SHALL be used; all other logic SHALL be in the top level.

Verification
REQ-034 start with p90=4, tau=10, p180=8, echo_num=3 -> pluse_load at cycle 1, state_start high for 4 cycles, then quar_delay for 10 cycles, then three 8-cycle pulses with phase=1 separated by 20-cycle gaps; done 1 cycle after the last gap; echo_cnt=3.
REQ-035 echo_num=0, p90=2, tau=3 -> no turn_delay; done on the cycle after TAU1; echo_cnt=0.
REQ-036 All lengths=0, echo_num=1 -> every timed state lasts exactly 1 cycle; total busy time is 6 cycles.
REQ-037 abort during the second P180 -> next cycle busy=0, state_start=0, no done; a following start runs a full sequence from the beginning.
REQ-038 start pulsed during GAP -> no effect; the run finishes with its original parameters, even if the inputs changed mid-run.
REQ-039 rst asserted during P90 -> all outputs 0 asynchronously; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/pluse_seq_ctrl_pkg.sv
// Shared definitions for the CPMG pulse sequencer: state encoding,
// counter widths and the "at least one cycle" length helper.
package pluse_seq_ctrl_pkg;

  localparam int CNT_W = 16;
  localparam int GAP_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_P90  = 3'd2,
    ST_TAU1 = 3'd3,
    ST_P180 = 3'd4,
    ST_GAP  = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  // A programmed length of zero still occupies one cycle.
  function automatic logic [GAP_W-1:0] at_least_one(input logic [GAP_W-1:0] len);
    return (len == '0) ? {{(GAP_W-1){1'b0}}, 1'b1} : len;
  endfunction

endpackage

// File: rtl/pluse_seq_ctrl_seq_timer.sv
// Loadable down-counter; tc flags the last cycle of the timed interval.
module seq_timer
  import pluse_seq_ctrl_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             tc
);

  logic [GAP_W-1:0] count;

  // Load on state entry, otherwise count down and rest at zero.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == {{(GAP_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pluse_seq_ctrl.sv
// CPMG pulse sequence controller: one 90-degree pulse, a tau gap, then
// echo_num 180-degree pulses each followed by a 2*tau gap.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one-cycle pluse_load strobe, parameters already latched
// P90   | 90-degree pulse, phase 0
// TAU1  | first half echo spacing, quar_delay high
// P180  | 180-degree refocusing pulse, phase 1
// GAP   | full echo spacing (2*tau) between refocusing pulses
// FIN   | one-cycle done strobe
module pluse_seq_ctrl
  import pluse_seq_ctrl_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] p90_len,
  input  logic [CNT_W-1:0] p180_len,
  input  logic [CNT_W-1:0] tau_len,
  input  logic [CNT_W-1:0] echo_num,
  output logic             pluse_load,
  output logic             state_start,
  output logic             phase,
  output logic             turn_delay,
  output logic             quar_delay,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] echo_cnt
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] p90_q, p180_q, tau_q, echo_num_q;
  logic             tmr_load, tmr_tc;
  logic [GAP_W-1:0] tmr_val;
  logic             run_start;

  assign run_start = (state == ST_IDLE) && (state_nxt == ST_LOAD);

  seq_timer u_seq_timer (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Capture the run parameters on the start edge; held until the next run.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      p90_q      <= '0;
      p180_q     <= '0;
      tau_q      <= '0;
      echo_num_q <= '0;
    end else if (run_start) begin
      p90_q      <= p90_len;
      p180_q     <= p180_len;
      tau_q      <= tau_len;
      echo_num_q <= echo_num;
    end
  end

  // Next state and timer reload; abort overrides everything.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start)  state_nxt = ST_LOAD;
        ST_LOAD: if (tmr_tc) state_nxt = ST_P90;
        ST_P90:  if (tmr_tc) state_nxt = ST_TAU1;
        ST_TAU1: if (tmr_tc) state_nxt = (echo_num_q != '0) ? ST_P180 : ST_FIN;
        ST_P180: if (tmr_tc) state_nxt = ST_GAP;
        ST_GAP:  if (tmr_tc) state_nxt = (echo_cnt < echo_num_q) ? ST_P180 : ST_FIN;
        ST_FIN:  if (tmr_tc) state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
    tmr_load = (state_nxt != state);
    case (state_nxt)
      ST_LOAD: tmr_val = at_least_one('0);
      ST_P90:  tmr_val = at_least_one({1'b0, p90_q});
      ST_TAU1: tmr_val = at_least_one({1'b0, tau_q});
      ST_P180: tmr_val = at_least_one({1'b0, p180_q});
      ST_GAP:  tmr_val = at_least_one({tau_q, 1'b0});
      ST_FIN:  tmr_val = at_least_one('0);
      default: tmr_val = '0;
    endcase
  end

  // Echo counter: cleared when a run starts, bumped as each P180 completes.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      echo_cnt <= '0;
    end else if (run_start) begin
      echo_cnt <= '0;
    end else if ((state == ST_P180) && (state_nxt == ST_GAP)) begin
      echo_cnt <= echo_cnt + 1'b1;
    end
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      pluse_load  <= 1'b0;
      state_start <= 1'b0;
      phase       <= 1'b0;
      turn_delay  <= 1'b0;
      quar_delay  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pluse_load  <= (state_nxt == ST_LOAD);
      state_start <= (state_nxt == ST_P90) || (state_nxt == ST_P180);
      phase       <= (state_nxt == ST_P180);
      turn_delay  <= (state_nxt == ST_P180) && (state != ST_P180);
      quar_delay  <= (state_nxt == ST_TAU1);
      busy        <= (state_nxt != ST_IDLE);
      done        <= (state_nxt == ST_FIN);
    end
  end

endmodule

// File: tb/tb_pluse_seq_ctrl.sv
// Self-checking bench for pluse_seq_ctrl: directed scenarios plus random
// runs compared cycle by cycle against an expected-waveform list.
module tb_pluse_seq_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [15:0] p90_len = '0, p180_len = '0, tau_len = '0, echo_num = '0;
  logic        pluse_load, state_start, phase, turn_delay, quar_delay, busy, done;
  logic [15:0] echo_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [22:0] exp_q[$];

  pluse_seq_ctrl dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .p90_len     (p90_len),
    .p180_len    (p180_len),
    .tau_len     (tau_len),
    .echo_num    (echo_num),
    .pluse_load  (pluse_load),
    .state_start (state_start),
    .phase       (phase),
    .turn_delay  (turn_delay),
    .quar_delay  (quar_delay),
    .busy        (busy),
    .done        (done),
    .echo_cnt    (echo_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (flags pl,ss,ph,td,qd,bz,dn | echo_cnt)", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] pk(input bit pl, input bit ss, input bit ph, input bit td,
                                     input bit qd, input bit bz, input bit dn, input int ec);
    logic [15:0] e;
    e = 16'(ec);
    return {pl, ss, ph, td, qd, bz, dn, e};
  endfunction

  function automatic logic [22:0] obs_vec();
    return {pluse_load, state_start, phase, turn_delay, quar_delay, busy, done, echo_cnt};
  endfunction

  function automatic int mx1(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Expected per-cycle outputs of a full run, starting at the cycle after start.
  task automatic build(input int p90, input int p180, input int tau, input int n);
    exp_q.delete();
    exp_q.push_back(pk(1, 0, 0, 0, 0, 1, 0, 0));
    repeat (mx1(p90)) exp_q.push_back(pk(0, 1, 0, 0, 0, 1, 0, 0));
    repeat (mx1(tau)) exp_q.push_back(pk(0, 0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < mx1(p180); j++) exp_q.push_back(pk(0, 1, 1, j == 0, 0, 1, 0, i));
      repeat (mx1(2 * tau)) exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 0, i + 1));
    end
    exp_q.push_back(pk(0, 0, 0, 0, 0, 1, 1, n));
  endtask

  // abort_at: -1 none, -2 random cycle, else cycle index at which abort is held.
  task automatic run_seq(input string name, input int p90, input int p180, input int tau,
                         input int n, input int abort_at, input bit noise);
    int a, last;
    logic [15:0] ec_hold;
    build(p90, p180, tau, n);
    a = abort_at;
    if (a == -2) a = int'($urandom_range(0, exp_q.size() - 1));
    last = (a >= 0 && a < exp_q.size()) ? a : exp_q.size() - 1;
    @(negedge clk_sys);
    p90_len = 16'(p90); p180_len = 16'(p180); tau_len = 16'(tau); echo_num = 16'(n);
    start = 1'b1;
    @(negedge clk_sys);
    for (int k = 0; k <= last; k++) begin
      start = 1'b0;
      abort = 1'b0;
      chk($sformatf("%s_c%0d", name, k), {9'd0, obs_vec()}, {9'd0, exp_q[k]});
      if (k == a) abort = 1'b1;
      if (noise && $urandom_range(0, 3) == 0) begin
        start    = 1'b1;
        p90_len  = 16'($urandom_range(0, 9));
        p180_len = 16'($urandom_range(0, 9));
        tau_len  = 16'($urandom_range(0, 9));
        echo_num = 16'($urandom_range(0, 6));
      end
      @(negedge clk_sys);
    end
    start = 1'b0;
    abort = 1'b0;
    ec_hold = exp_q[last][15:0];
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_idle%0d", name, k), {9'd0, obs_vec()}, {9'd0, pk(0, 0, 0, 0, 0, 0, 0, int'(ec_hold))});
      @(negedge clk_sys);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_sys);
    chk("reset_state", {9'd0, obs_vec()}, 32'd0);
    rst = 1'b0;
    @(negedge clk_sys);
    chk("post_reset_idle", {9'd0, obs_vec()}, 32'd0);

    run_seq("basic", 4, 8, 10, 3, -1, 1'b0);
    run_seq("no_echo", 2, 5, 3, 0, -1, 1'b0);
    run_seq("all_zero", 0, 0, 0, 1, -1, 1'b0);
    run_seq("abort_p180b", 3, 5, 4, 3, 23, 1'b0);
    run_seq("after_abort", 3, 5, 4, 3, -1, 1'b0);
    run_seq("noise_gap", 2, 3, 4, 3, -1, 1'b1);

    // start and abort together in IDLE: abort wins
    @(negedge clk_sys);
    start = 1'b1; abort = 1'b1;
    @(negedge clk_sys);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", {31'd0, busy}, 32'd0);
    @(negedge clk_sys);
    chk("start_abort_idle_load", {31'd0, pluse_load}, 32'd0);

    // reset during P90 clears outputs without waiting for a clock edge
    @(negedge clk_sys);
    p90_len = 16'd8; p180_len = 16'd2; tau_len = 16'd2; echo_num = 16'd2;
    start = 1'b1;
    @(negedge clk_sys);
    start = 1'b0;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    chk("p90_before_rst", {31'd0, state_start}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {9'd0, obs_vec()}, 32'd0);
    @(negedge clk_sys);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      chk($sformatf("rst_wait%0d", k), {9'd0, obs_vec()}, 32'd0);
    end
    run_seq("after_rst", 1, 2, 1, 2, -1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      run_seq($sformatf("rnd%0d", r),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? -2 : -1, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
